step_timing_shaper: RTL and testbench
=====================================

STEP_TIMING_SHAPER -- requirements
Module: step_timing_shaper

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, step-event queue depth (power of 2, ≥2).
REQ-002 SHALL have parameter CW, default 16, width of timing-count registers.
REQ-003 SHALL have port clk  input  1  single system clock (50 MHz); all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports step_in / dir_in  input  1 each  raw STEP/DIR from stepper_driver, same clock domain.
REQ-006 SHALL have port avs_s0_address  input  3  CSR word address.
REQ-007 SHALL have ports avs_s0_write / avs_s0_read  input  1 each, and avs_s0_writedata  input  32.
REQ-008 SHALL have ports avs_s0_readdata  output  32 (registered) and avs_s0_waitrequest  output  1 (tied 0).
REQ-009 SHALL have ports step_out / dir_out  output  1 each  timing-compliant STEP/DIR to the external driver pins.

Function
REQ-010 SHALL detect a step event when step_in=1 and the prior-cycle step_in=0, pushing dir_in from that cycle into the FIFO at the end of the same cycle.
REQ-011 SHALL use FSM states IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW.
REQ-012 IDLE: on non-empty FIFO, pop head; if head dir ≠ dir_out, drive dir_out=head dir and go DIR_SETUP, else go PULSE_HIGH.
REQ-013 DIR_SETUP: hold step_out=0 for max(dir_setup,1) cycles, then go PULSE_HIGH.
REQ-014 PULSE_HIGH: step_out=1 for max(pulse_high,1) cycles, then go PULSE_LOW; on entry, position += 1 if dir_out=0, else -= 1 (32-bit two's-complement wrap).
REQ-015 PULSE_LOW: step_out=0 and dir_out held for max(pulse_low,1) cycles, then go IDLE.
REQ-016 SHALL latch each timing value at phase entry; CSR writes mid-phase take effect from the next phase.
REQ-017 Latency: edge detected in cycle N with FIFO empty, FSM IDLE, and no dir change -> step_out=1 in cycle N+2.
REQ-018 FIFO full with no pop in the same cycle: drop the event, increment drop_count (saturate at 2^32-1), set sticky overflow.
REQ-019 FIFO full with a pop in the same cycle: accept the push.
REQ-020 CSR map: 0 pulse_high (RW, CW bits); 1 pulse_low (RW); 2 dir_setup (RW); 3 status (R: bit0 overflow, bit1 busy = state≠IDLE or FIFO non-empty, bits[7:4] FIFO level; W: bit0=1 clears overflow); 4 position (RW signed 32); 5 drop_count (R; any write clears); others read 0xDEADBEEF.
REQ-021 Reads return data in avs_s0_readdata the cycle after avs_s0_read; readdata otherwise holds its last value.
REQ-022 A position write coincident with PULSE_HIGH entry SHALL win (written value stored, step not counted).
REQ-023 A write clearing overflow coincident with a new drop SHALL leave overflow=1.

Reset
REQ-024 While reset=1, outputs and state take: step_out=0, dir_out=0, readdata=0, FSM=IDLE, FIFO empty, position=0, drop_count=0, overflow=0, edge-detect register=0.
REQ-025 Timing registers reset to pulse_high=100, pulse_low=100, dir_setup=250.
REQ-026 Reset asserted mid-pulse SHALL drop step_out to 0 the cycle after reset is sampled and discard queued events.

Structure
REQ-027 CSR address constants, FSM state encoding, and default timing values SHALL live in shared package stepper_pkg.
REQ-028 The FIFO SHALL be a separate sub-module step_event_fifo (1-bit data, FIFO_DEPTH entries, push/pop/full/empty/level).

Verification
REQ-029 Reset -> reads return addr0=100, addr2=250, addr4=0, addr3=0; step_out=0.
REQ-030 Single edge, dir_in=0 -> step_out high N+2..N+101, low 100 cycles; position=1.
REQ-031 Edge with dir_in=1 -> dir_out=1 at N+2; step_out rises at N+252; position=-1.
REQ-032 Six edges 2 cycles apart, dir=0 -> 5 pulses, drop_count=1, overflow=1; write status bit0 -> overflow=0.
REQ-033 Position write 0x100 coincident with PULSE_HIGH entry -> position reads 0x100.
REQ-034 Reset pulse mid-PULSE_HIGH with 3 queued events -> step_out=0 next cycle; no further pulses; busy=0.

Source files
------------

// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared constants, FSM encoding and helpers for the step timing shaper
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DIR_SETUP  = 2'd1,
    ST_PULSE_HIGH = 2'd2,
    ST_PULSE_LOW  = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_PULSE_HIGH = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LOW  = 3'd1;
  localparam logic [2:0] ADDR_DIR_SETUP  = 3'd2;
  localparam logic [2:0] ADDR_STATUS     = 3'd3;
  localparam logic [2:0] ADDR_POSITION   = 3'd4;
  localparam logic [2:0] ADDR_DROP_COUNT = 3'd5;

  localparam int DEF_PULSE_HIGH = 100;
  localparam int DEF_PULSE_LOW  = 100;
  localparam int DEF_DIR_SETUP  = 250;

  localparam logic [31:0] UNMAPPED_READ = 32'hDEAD_BEEF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/step_timing_shaper_if.sv
// rtl/step_timing_shaper_if.sv - CSR bus bundle between a host and the step timing shaper
interface step_timing_shaper_if;
  logic [2:0]  avs_s0_address;
  logic        avs_s0_write;
  logic        avs_s0_read;
  logic [31:0] avs_s0_writedata;
  logic [31:0] avs_s0_readdata;
  logic        avs_s0_waitrequest;

  modport master (
    output avs_s0_address, avs_s0_write, avs_s0_read, avs_s0_writedata,
    input  avs_s0_readdata, avs_s0_waitrequest
  );

  modport slave (
    input  avs_s0_address, avs_s0_write, avs_s0_read, avs_s0_writedata,
    output avs_s0_readdata, avs_s0_waitrequest
  );
endinterface

// File: rtl/step_event_fifo.sv
// rtl/step_event_fifo.sv - small queue of pending step directions (1-bit entries)
module step_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   din_i,
  input  logic                   pop_i,
  output logic                   dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  // Depth is a power of two, so the level MSB alone means full.
  assign empty_o = (level_q == '0);
  assign full_o  = level_q[AW];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointer/level bookkeeping; a push into a full queue is accepted when a pop frees a slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LVL_ONE;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LVL_ONE;
      end
    end
  end
endmodule

// File: rtl/step_timing_shaper.sv
// rtl/step_timing_shaper.sv - re-times raw STEP/DIR into pulses meeting driver setup/width limits
module step_timing_shaper
  import stepper_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_in,
  input  logic                 dir_in,
  step_timing_shaper_if.slave  avs,
  output logic                 step_out,
  output logic                 dir_out
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] pulse_high_q;
  logic [CW-1:0] pulse_low_q;
  logic [CW-1:0] dir_setup_q;
  logic          step_out_q;
  logic          dir_out_q;
  logic          step_prev_q;
  logic          overflow_q, overflow_d;
  logic [31:0]   position_q, position_d;
  logic [31:0]   drop_count_q, drop_count_d;
  logic [31:0]   readdata_q, readdata_d;

  logic          edge_det;
  logic          fifo_pop;
  logic          fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          drop;
  logic          enter_high;
  logic          busy;
  logic          wr_status;
  logic          wr_position;
  logic          wr_drop;

  // Cycle count for a phase of length max(v,1): counter runs down to zero inclusive.
  function automatic logic [CW-1:0] phase_len(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  step_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (edge_det),
    .din_i   (dir_in),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign edge_det    = step_in & ~step_prev_q;
  assign fifo_pop    = (state_q == ST_IDLE) & ~fifo_empty;
  assign drop        = edge_det & fifo_full & ~fifo_pop;
  assign enter_high  = (fifo_pop & (fifo_dout == dir_out_q)) |
                       ((state_q == ST_DIR_SETUP) & (cnt_q == '0));
  assign busy        = (state_q != ST_IDLE) | ~fifo_empty;
  assign wr_status   = avs.avs_s0_write & (avs.avs_s0_address == ADDR_STATUS);
  assign wr_position = avs.avs_s0_write & (avs.avs_s0_address == ADDR_POSITION);
  assign wr_drop     = avs.avs_s0_write & (avs.avs_s0_address == ADDR_DROP_COUNT);

  assign step_out               = step_out_q;
  assign dir_out                = dir_out_q;
  assign avs.avs_s0_readdata    = readdata_q;
  assign avs.avs_s0_waitrequest = 1'b0;

  // Next-state for position, drop accounting and read mux; host writes take priority except a fresh drop keeps overflow set.
  always_comb begin
    position_d = position_q;
    if (enter_high) begin
      position_d = dir_out_q ? position_q - 32'd1 : position_q + 32'd1;
    end
    if (wr_position) begin
      position_d = avs.avs_s0_writedata;
    end

    overflow_d = overflow_q;
    if (wr_status && avs.avs_s0_writedata[0]) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    drop_count_d = drop ? sat_inc32(drop_count_q) : drop_count_q;
    if (wr_drop) begin
      drop_count_d = '0;
    end

    readdata_d = readdata_q;
    if (avs.avs_s0_read) begin
      case (avs.avs_s0_address)
        ADDR_PULSE_HIGH: readdata_d = 32'(pulse_high_q);
        ADDR_PULSE_LOW:  readdata_d = 32'(pulse_low_q);
        ADDR_DIR_SETUP:  readdata_d = 32'(dir_setup_q);
        ADDR_STATUS:     readdata_d = {24'd0, 4'(fifo_level), 2'b00, busy, overflow_q};
        ADDR_POSITION:   readdata_d = position_q;
        ADDR_DROP_COUNT: readdata_d = drop_count_q;
        default:         readdata_d = UNMAPPED_READ;
      endcase
    end
  end

  // CSR storage, edge detector and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_high_q <= CW'(DEF_PULSE_HIGH);
      pulse_low_q  <= CW'(DEF_PULSE_LOW);
      dir_setup_q  <= CW'(DEF_DIR_SETUP);
      step_prev_q  <= 1'b0;
      overflow_q   <= 1'b0;
      position_q   <= '0;
      drop_count_q <= '0;
      readdata_q   <= '0;
    end else begin
      if (avs.avs_s0_write && avs.avs_s0_address == ADDR_PULSE_HIGH) pulse_high_q <= CW'(avs.avs_s0_writedata);
      if (avs.avs_s0_write && avs.avs_s0_address == ADDR_PULSE_LOW)  pulse_low_q  <= CW'(avs.avs_s0_writedata);
      if (avs.avs_s0_write && avs.avs_s0_address == ADDR_DIR_SETUP)  dir_setup_q  <= CW'(avs.avs_s0_writedata);
      step_prev_q  <= step_in;
      overflow_q   <= overflow_d;
      position_q   <= position_d;
      drop_count_q <= drop_count_d;
      readdata_q   <= readdata_d;
    end
  end

  // Pulse sequencer: timing values are sampled into cnt_q on phase entry, so mid-phase writes wait for the next phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      step_out_q <= 1'b0;
      dir_out_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (fifo_dout != dir_out_q) begin
              dir_out_q <= fifo_dout;
              cnt_q     <= phase_len(dir_setup_q);
              state_q   <= ST_DIR_SETUP;
            end else begin
              step_out_q <= 1'b1;
              cnt_q      <= phase_len(pulse_high_q);
              state_q    <= ST_PULSE_HIGH;
            end
          end
        end
        ST_DIR_SETUP: begin
          if (cnt_q == '0) begin
            step_out_q <= 1'b1;
            cnt_q      <= phase_len(pulse_high_q);
            state_q    <= ST_PULSE_HIGH;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_PULSE_HIGH: begin
          if (cnt_q == '0) begin
            step_out_q <= 1'b0;
            cnt_q      <= phase_len(pulse_low_q);
            state_q    <= ST_PULSE_LOW;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_PULSE_LOW: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_step_timing_shaper.sv
// tb/tb_step_timing_shaper.sv - directed scoreboard bench for step_timing_shaper
module tb_step_timing_shaper;
  logic clk = 1'b0;
  logic reset;
  logic step_in;
  logic dir_in;
  logic step_out;
  logic dir_out;

  step_timing_shaper_if avs_if ();

  step_timing_shaper #(.FIFO_DEPTH(4), .CW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .step_in  (step_in),
    .dir_in   (dir_in),
    .avs      (avs_if),
    .step_out (step_out),
    .dir_out  (dir_out)
  );

  always #10 clk = ~clk;

  typedef struct {
    int   rise;
    int   width;
    logic dir;
  } pulse_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  pulse_t      pulse_obs[$];
  pulse_t      pulse_exp[$];
  logic [31:0] rd_exp[$];
  int          mon_rise = 0;
  logic        mon_dir = 1'b0;
  logic        mon_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each completed step_out pulse: rise cycle, high width, dir at rise.
  always @(negedge clk) begin
    pulse_t p;
    if (step_out === 1'b1 && mon_prev === 1'b0) begin
      mon_rise = cyc;
      mon_dir  = dir_out;
    end
    if (step_out === 1'b0 && mon_prev === 1'b1) begin
      p.rise  = mon_rise;
      p.width = cyc - mon_rise;
      p.dir   = mon_dir;
      pulse_obs.push_back(p);
    end
    mon_prev = step_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int rise, input int width, input logic dir);
    pulse_t p;
    p.rise  = rise;
    p.width = width;
    p.dir   = dir;
    pulse_exp.push_back(p);
  endtask

  task automatic check_pulses(input string tag);
    pulse_t o;
    pulse_t e;
    chk({tag, "_count"}, pulse_obs.size(), pulse_exp.size());
    while (pulse_exp.size() > 0 && pulse_obs.size() > 0) begin
      e = pulse_exp.pop_front();
      o = pulse_obs.pop_front();
      chk({tag, "_rise"}, o.rise, e.rise);
      chk({tag, "_width"}, o.width, e.width);
      chk({tag, "_dir"}, o.dir, e.dir);
    end
    pulse_exp.delete();
    pulse_obs.delete();
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    avs_if.avs_s0_address   = a;
    avs_if.avs_s0_writedata = d;
    avs_if.avs_s0_write     = 1'b1;
    tick();
    avs_if.avs_s0_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    rd_exp.push_back(exp);
    avs_if.avs_s0_address = a;
    avs_if.avs_s0_read    = 1'b1;
    tick();
    avs_if.avs_s0_read    = 1'b0;
    chk(tag, avs_if.avs_s0_readdata, rd_exp.pop_front());
  endtask

  task automatic step_edge(input logic d);
    step_in = 1'b1;
    dir_in  = d;
    tick();
    step_in = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    step_in = 1'b0;
    dir_in = 1'b0;
    avs_if.avs_s0_address = '0;
    avs_if.avs_s0_write = 1'b0;
    avs_if.avs_s0_read = 1'b0;
    avs_if.avs_s0_writedata = '0;
    repeat (3) tick();
    chk("rst_step_out", step_out, 32'd0);
    chk("rst_dir_out", dir_out, 32'd0);
    chk("rst_readdata", avs_if.avs_s0_readdata, 32'd0);
    chk("waitrequest", avs_if.avs_s0_waitrequest, 32'd0);
    reset = 1'b0;
    tick();
    csr_read(3'd0, 32'd100, "rd_pulse_high");
    csr_read(3'd1, 32'd100, "rd_pulse_low");
    csr_read(3'd2, 32'd250, "rd_dir_setup");
    csr_read(3'd3, 32'd0, "rd_status");
    csr_read(3'd4, 32'd0, "rd_position");
    csr_read(3'd5, 32'd0, "rd_drop_count");
    csr_read(3'd6, 32'hDEAD_BEEF, "rd_unmapped6");
    csr_read(3'd7, 32'hDEAD_BEEF, "rd_unmapped7");

    // Single forward step: rises at N+2, 100 high, 100 low, then idle.
    n = cyc;
    expect_pulse(n + 2, 100, 1'b0);
    step_edge(1'b0);
    wait_cyc(n + 201);
    csr_read(3'd3, 32'h2, "busy_last_low");
    csr_read(3'd3, 32'h0, "idle_after_low");
    csr_read(3'd4, 32'd1, "pos_fwd");
    check_pulses("single_fwd");

    // Reverse step: dir switches at N+2, step rises after 250-cycle setup.
    n = cyc;
    expect_pulse(n + 252, 100, 1'b1);
    step_in = 1'b1;
    dir_in = 1'b1;
    tick();
    chk("dir_hold", dir_out, 32'd0);
    step_in = 1'b0;
    tick();
    chk("dir_switch", dir_out, 32'd1);
    wait_cyc(n + 460);
    csr_read(3'd4, 32'd0, "pos_rev");
    check_pulses("dir_change");

    // Zero timing values behave as one cycle.
    csr_write(3'd0, 32'd0);
    csr_write(3'd1, 32'd0);
    csr_write(3'd2, 32'd0);
    n = cyc;
    expect_pulse(n + 3, 1, 1'b0);
    step_edge(1'b0);
    wait_cyc(n + 12);
    check_pulses("zero_timing");

    // Mid-phase pulse_high write does not stretch the pulse in progress.
    csr_write(3'd0, 32'd3);
    n = cyc;
    expect_pulse(n + 2, 3, 1'b0);
    step_edge(1'b0);
    csr_write(3'd0, 32'd7);
    wait_cyc(n + 12);
    csr_read(3'd4, 32'd2, "pos_short");
    check_pulses("latch_timing");

    csr_write(3'd0, 32'd100);
    csr_write(3'd1, 32'd100);
    csr_write(3'd2, 32'd250);

    // Six edges two cycles apart: five pulses, one drop; overflow clear on the drop cycle loses.
    n = cyc;
    for (int k = 0; k < 5; k++) expect_pulse(n + 2 + 201 * k, 100, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step_in = 1'b1;
      dir_in = 1'b0;
      if (i == 5) begin
        avs_if.avs_s0_address = 3'd3;
        avs_if.avs_s0_writedata = 32'd1;
        avs_if.avs_s0_write = 1'b1;
      end
      tick();
      step_in = 1'b0;
      avs_if.avs_s0_write = 1'b0;
      tick();
    end
    csr_read(3'd3, 32'h43, "status_full_ovf");
    csr_read(3'd5, 32'd1, "drop_count");
    wait_cyc(n + 1011);
    csr_read(3'd3, 32'h1, "ovf_sticky");
    csr_write(3'd3, 32'd1);
    csr_read(3'd3, 32'h0, "ovf_cleared");
    csr_read(3'd4, 32'd7, "pos_burst");
    csr_write(3'd5, 32'd0);
    csr_read(3'd5, 32'd0, "drop_cleared");
    check_pulses("burst");

    // Position write landing on the PULSE_HIGH entry cycle wins.
    n = cyc;
    expect_pulse(n + 2, 100, 1'b0);
    step_in = 1'b1;
    dir_in = 1'b0;
    tick();
    step_in = 1'b0;
    avs_if.avs_s0_address = 3'd4;
    avs_if.avs_s0_writedata = 32'h100;
    avs_if.avs_s0_write = 1'b1;
    tick();
    avs_if.avs_s0_write = 1'b0;
    wait_cyc(n + 210);
    csr_read(3'd4, 32'h100, "pos_write_wins");
    check_pulses("pos_race");

    // Reset mid-pulse with three events queued.
    n = cyc;
    expect_pulse(n + 2, 19, 1'b0);
    for (int i = 0; i < 4; i++) step_edge(1'b0);
    wait_cyc(n + 20);
    chk("pre_reset_high", step_out, 32'd1);
    reset = 1'b1;
    tick();
    chk("reset_drops_step", step_out, 32'd0);
    chk("reset_readdata", avs_if.avs_s0_readdata, 32'd0);
    reset = 1'b0;
    wait_cyc(n + 600);
    check_pulses("reset_mid");
    csr_read(3'd3, 32'h0, "busy_after_reset");
    csr_read(3'd4, 32'd0, "pos_after_reset");
    csr_read(3'd0, 32'd100, "ph_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
